// File: rtl/jk_pkg.sv
// Shared JK flip-flop operation codes and the excitation helper
// used by the counter bank.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Returns {J,K} that moves a cell from cur to nxt without toggling.
    function automatic logic [1:0] jk_excite(
        input logic cur,
        input logic nxt
    );
        return {nxt & ~cur, ~nxt & cur};
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset.
// Supports hold, reset, set and toggle.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic nq
);

    logic state_q;
    logic state_d;

    always_comb begin
        state_d = state_q;
        unique case ({j, k})
            JK_HOLD: state_d = state_q;
            JK_RST:  state_d = 1'b0;
            JK_SET:  state_d = 1'b1;
            JK_TGL:  state_d = ~state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign q  = state_q;
    assign nq = ~state_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter with load, held entirely in JK cells,
// plus terminal-count, wrap and load-error flags.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_mod_counter: MODULUS out of range for WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] cnt_n;
    logic             wrap_q;
    logic             wrap_d;
    logic             load_err_q;
    logic             load_err_d;
    logic             at_max;
    logic             at_zero;
    logic             in_range;
    logic [1:0]       jk [WIDTH];

    assign at_max   = (cnt_q == MAX_V);
    assign at_zero  = (cnt_q == '0);
    assign in_range = ({1'b0, din} < MOD_W);

    always_comb begin
        cnt_d      = cnt_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            cnt_d      = in_range ? din : '0;
            load_err_d = ~in_range;
        end else if (en) begin
            if (up) begin
                cnt_d  = at_max ? '0 : cnt_q + WIDTH'(1);
                wrap_d = at_max;
            end else begin
                cnt_d  = at_zero ? MAX_V : cnt_q - WIDTH'(1);
                wrap_d = at_zero;
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        assign jk[g] = jk_excite(cnt_q[g], cnt_d[g]);
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (jk[g][1]),
            .k     (jk[g][0]),
            .q     (cnt_q[g]),
            .nq    (cnt_n[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign q        = cnt_q;
    assign qn       = cnt_n;
    assign tc       = en & ~load & (up ? at_max : at_zero);
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: MODULUS=7 and MODULUS=8 instances share
// stimulus and are compared against a modular-arithmetic model.
module tb_jk_mod_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up;
    logic       load;
    logic [2:0] din;

    logic [2:0] q7, qn7, q8, qn8;
    logic       tc7, wrap7, err7, tc8, wrap8, err8;

    int checks;
    int failures;

    int mods [2] = '{7, 8};
    int m_q [2];
    int m_wrap [2];
    int m_err [2];

    jk_mod_counter #(.WIDTH(3), .MODULUS(7)) u_dut7 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .din      (din),
        .q        (q7),
        .qn       (qn7),
        .tc       (tc7),
        .wrap     (wrap7),
        .load_err (err7)
    );

    jk_mod_counter #(.WIDTH(3), .MODULUS(8)) u_dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .din      (din),
        .q        (q8),
        .qn       (qn8),
        .tc       (tc8),
        .wrap     (wrap8),
        .load_err (err8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int exp_tc(input int i);
        int m;
        m = mods[i];
        if (!en || load) return 0;
        return up ? int'(m_q[i] == m - 1) : int'(m_q[i] == 0);
    endfunction

    task automatic model_edge();
        int m;
        int d;
        d = int'(din);
        for (int i = 0; i < 2; i++) begin
            m = mods[i];
            if (load) begin
                m_wrap[i] = 0;
                if (d < m) begin
                    m_q[i]   = d;
                    m_err[i] = 0;
                end else begin
                    m_q[i]   = 0;
                    m_err[i] = 1;
                end
            end else begin
                m_err[i]  = 0;
                m_wrap[i] = 0;
                if (en && up) begin
                    m_wrap[i] = int'(m_q[i] == m - 1);
                    m_q[i]    = (m_q[i] + 1) % m;
                end else if (en) begin
                    m_wrap[i] = int'(m_q[i] == 0);
                    m_q[i]    = (m_q[i] + m - 1) % m;
                end
            end
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".q7"}, int'(q7), m_q[0]);
        chk({tag, ".qn7"}, int'(qn7), 7 - m_q[0]);
        chk({tag, ".wrap7"}, int'(wrap7), m_wrap[0]);
        chk({tag, ".err7"}, int'(err7), m_err[0]);
        chk({tag, ".q8"}, int'(q8), m_q[1]);
        chk({tag, ".qn8"}, int'(qn8), 7 - m_q[1]);
        chk({tag, ".wrap8"}, int'(wrap8), m_wrap[1]);
        chk({tag, ".err8"}, int'(err8), m_err[1]);
    endtask

    task automatic cycle(
        input string tag,
        input logic  e,
        input logic  u,
        input logic  l,
        input int    d
    );
        @(negedge clk);
        en   = e;
        up   = u;
        load = l;
        din  = 3'(d);
        #1;
        chk({tag, ".tc7"}, int'(tc7), exp_tc(0));
        chk({tag, ".tc8"}, int'(tc8), exp_tc(1));
        @(posedge clk);
        model_edge();
        #1;
        chk_state(tag);
    endtask

    task automatic mid_reset(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            m_q[i]    = 0;
            m_wrap[i] = 0;
            m_err[i]  = 0;
        end
        chk_state(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        din      = '0;
        for (int i = 0; i < 2; i++) begin
            m_q[i]    = 0;
            m_wrap[i] = 0;
            m_err[i]  = 0;
        end
        #2;
        chk_state("reset0");
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) cycle("up", 1'b1, 1'b1, 1'b0, 0);

        cycle("ld0", 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) cycle("down", 1'b1, 1'b0, 1'b0, 0);

        cycle("ld5", 1'b1, 1'b1, 1'b1, 5);
        cycle("ld5h", 1'b0, 1'b1, 1'b0, 0);
        cycle("ld7", 1'b1, 1'b1, 1'b1, 7);
        cycle("ld7h", 1'b0, 1'b1, 1'b0, 0);

        cycle("ld3", 1'b0, 1'b1, 1'b1, 3);
        for (int i = 0; i < 3; i++) cycle("hold", 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) cycle("flip", 1'b1, ((i % 2) == 0), 1'b0, 0);

        cycle("ld7b", 1'b0, 1'b1, 1'b1, 7);
        cycle("wrap8", 1'b1, 1'b1, 1'b0, 0);
        mid_reset("rst_mid");
        cycle("post_rst", 1'b0, 1'b1, 1'b0, 0);

        for (int n = 0; n < 400; n++) begin
            cycle("rnd",
                  1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 7)));
            if ($urandom_range(0, 49) == 0) mid_reset("rnd_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
